vga_pmod_timing: RTL and testbench
==================================

# vga_pmod_timing

Parametrised VGA timing generator and PMOD pixel output stage for the iCE40 board designs, running in the PLL clock domain. It generates horizontal/vertical counters, sync and blanking, and presents pixel coordinates to a pixel source ahead of time. It then re-aligns the returned RGB with delayed sync so the PMOD pins carry a coherent frame for any resolution, sync polarity, colour depth and pixel-source latency.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches / sync in lines
- H_POL / V_POL, 0 / 0, sync active level (0 = active-low)
- COLOR_W, 4, bits per colour channel (PMOD width)
- PIX_LAT, 2, cycles from x_o/y_o to valid rgb_*_i (0..15)

Ports (one clock; reset is synchronous and active-high):
- pll_clk  in  1  pixel-domain clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  pixel clock enable; all state advances only when high
- x_o  out  clog2(H_TOTAL)  current horizontal counter
- y_o  out  clog2(V_TOTAL)  current vertical counter
- active_o  out  1  x_o < H_ACTIVE and y_o < V_ACTIVE
- sof_o  out  1  one-enabled-cycle pulse at x=0, y=0
- rgb_r_i / rgb_g_i / rgb_b_i  in  COLOR_W  pixel colour, PIX_LAT enabled cycles after its x_o/y_o
- test_pat_i  in  1  select internal colour bars (only with VGA_TEST_PATTERN_EN)
- vga_r_o / vga_g_o / vga_b_o  out  COLOR_W  registered PMOD colour
- vga_hs_o / vga_vs_o  out  1  registered sync
- frame_cnt_o  out  16  completed frame count

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- x counts 0..H_TOTAL-1, wraps to 0 and increments y. y wraps at V_TOTAL-1 to 0; frame_cnt increments on that wrap, modulo 2^16.
- hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on y. Output level = polarity parameter when asserted, inverse otherwise.
- active, hsync and vsync are delayed PIX_LAT enabled cycles, then registered with the colour. Colour is forced to 0 when the delayed active bit is low.
- pix_en low: counters, delay line and output registers hold. sof_o is 0.
- Pipeline valid bits are cleared by reset. Pins stay blanked with syncs inactive until PIX_LAT+1 enabled cycles have passed.
- Reset mid-frame: next cycle x=0, y=0, frame_cnt=0, outputs at reset values. The frame restarts cleanly with no partial-line sync glitch.

## Timing
- Reset values: x_o=0, y_o=0, active_o=1 (x=0,y=0 is active), sof_o=0, frame_cnt_o=0, vga_*_o colour=0, vga_hs_o=~H_POL, vga_vs_o=~V_POL.
- sof_o is first asserted on the first enabled cycle after reset release.
- x_o/y_o to pins: PIX_LAT+1 enabled cycles. Sync and colour for the same pixel leave on the same edge.
- PIX_LAT=0: colour is sampled the same cycle as x_o and registered once.

## Configuration
- VGA_TEST_PATTERN_EN defined: test_pat_i exists. When it is high, colour is replaced with 8 vertical bars, each H_ACTIVE/8 wide, computed from the delayed x. Order: white, yellow, cyan, green, magenta, red, blue, black; each channel is all-ones or 0. Sync timing is unchanged.
- VGA_TEST_PATTERN_EN undefined: no test_pat_i port and no bar logic; colour always comes from rgb_*_i.

## Structure
- Package vga_pkg: timing struct typedef (active/fp/sync/bp per axis), localparams for 640x480@60 and 800x600@60, and a bar-colour constant array.
- Sub-module vga_delay_line: parametrised width/depth shift register with enable and synchronous clear. It carries {active, hs, vs} and, under the macro, the bar index.

## Test plan
- Small timing (H 8/2/2/2, V 4/1/1/1, PIX_LAT=2), pix_en=1 -> hs pulses 2 cycles wide every 14 cycles; vs spans exactly 14 cycles; sof_o period 98 cycles; frame_cnt_o=3 after 294 cycles.
- rgb_*_i = x_o[3:0] delayed by 2 -> pin colour equals the originating x for active pixels and 0 in blanking; alignment holds for PIX_LAT 0, 1 and 5.
- H_POL=1, V_POL=1 -> syncs idle low and pulse high, at the same positions as the first test.
- pix_en toggled 1/0 every cycle -> same waveform as the first test at half rate, with no lost or duplicated pixels.
- rst asserted at x=5, y=2 for 1 cycle -> next cycle x_o=0, y_o=0, frame_cnt_o=0; pins blanked for 3 enabled cycles.
- With VGA_TEST_PATTERN_EN, H_ACTIVE=640, test_pat_i=1 -> pixels 0..79 colour F/F/F, 80..159 F/F/0, 560..639 0/0/0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: per-axis timing struct, standard modes,
// and the colour-bar table used by the optional test pattern
// (enabled with VGA_TEST_PATTERN_EN).
package vga_pkg;

    // One axis of a video mode, in pixels (horizontal) or lines (vertical).
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33}
    };

    localparam vga_timing_t VGA_800X600_60 = '{
        h: '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88},
        v: '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23}
    };

    // Number of vertical colour bars drawn by the test pattern.
    localparam int BAR_COUNT = 8;

    // Bar colours left to right as {r, g, b} enable bits:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [2:0] BAR_RGB [BAR_COUNT] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    // Total length of one axis (visible + porches + sync).
    function automatic int axis_total(input vga_axis_t a);
        return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of parametrised width and depth with synchronous
// clear. DEPTH = 0 degenerates to a wire so the caller needs no special case.
module vga_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en};
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        // Shift one stage per enabled cycle; clear drops every in-flight entry.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= '0;
                end
            end else if (en) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_pmod_timing.sv
// VGA timing generator and PMOD output stage. Counters present x/y to a
// pixel source PIX_LAT enabled cycles ahead; blanking and sync flags travel
// through a matching delay line so colour and sync leave on the same edge.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN.
module vga_pmod_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = int'(VGA_640X480_60.h.active),
    parameter int H_FP     = int'(VGA_640X480_60.h.fp),
    parameter int H_SYNC   = int'(VGA_640X480_60.h.sync),
    parameter int H_BP     = int'(VGA_640X480_60.h.bp),
    parameter int V_ACTIVE = int'(VGA_640X480_60.v.active),
    parameter int V_FP     = int'(VGA_640X480_60.v.fp),
    parameter int V_SYNC   = int'(VGA_640X480_60.v.sync),
    parameter int V_BP     = int'(VGA_640X480_60.v.bp),
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int PIX_LAT  = 2
) (
    input  logic                                                  pll_clk,
    input  logic                                                  rst,
    input  logic                                                  pix_en,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]          x_o,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]          y_o,
    output logic                                                  active_o,
    output logic                                                  sof_o,
    input  logic [COLOR_W-1:0]                                    rgb_r_i,
    input  logic [COLOR_W-1:0]                                    rgb_g_i,
    input  logic [COLOR_W-1:0]                                    rgb_b_i,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                                                  test_pat_i,
`endif
    output logic [COLOR_W-1:0]                                    vga_r_o,
    output logic [COLOR_W-1:0]                                    vga_g_o,
    output logic [COLOR_W-1:0]                                    vga_b_o,
    output logic                                                  vga_hs_o,
    output logic                                                  vga_vs_o,
    output logic [15:0]                                           frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

`ifdef VGA_TEST_PATTERN_EN
    // Bars are H_ACTIVE/8 wide; guard against tiny test modes.
    localparam int BAR_W  = (H_ACTIVE / BAR_COUNT > 0) ? H_ACTIVE / BAR_COUNT : 1;
    localparam int BAR_IW = 3;
    localparam int DL_W   = 4 + BAR_IW;
`else
    localparam int DL_W   = 4;
`endif

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [15:0]    frame_q;

    // Advance x every enabled cycle; wrap into y and then into the frame count.
    always_ff @(posedge pll_clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else if (pix_en) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                if (y_q == Y_LAST) begin
                    y_q     <= '0;
                    frame_q <= frame_q + 16'd1;
                end else begin
                    y_q <= y_q + 1'b1;
                end
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-position flags, derived from the live counters
    // ------------------------------------------------------------------
    int   x_int;
    int   y_int;
    logic h_act;
    logic v_act;
    logic hs_act;
    logic vs_act;
    logic pos_active;

    assign x_int = 32'(x_q);
    assign y_int = 32'(y_q);

    // Decode visible area and sync windows; hs/vs here mean "sync asserted".
    always_comb begin
        h_act      = (x_int < H_ACTIVE);
        v_act      = (y_int < V_ACTIVE);
        hs_act     = (x_int >= HS_START) && (x_int < HS_END);
        vs_act     = (y_int >= VS_START) && (y_int < VS_END);
        pos_active = h_act && v_act;
    end

    assign x_o         = x_q;
    assign y_o         = y_q;
    assign active_o    = pos_active;
    assign frame_cnt_o = frame_q;
    // Start-of-frame only counts on a cycle that actually advances the raster.
    assign sof_o       = pix_en && !rst && (x_q == '0) && (y_q == '0);

    // ------------------------------------------------------------------
    // Delay line: holds {valid, active, hs, vs[, bar]} for PIX_LAT cycles so
    // the flags meet the colour the pixel source returns for that position.
    // The valid bit is cleared by reset, which keeps the pins blank with
    // syncs idle until the first real pixel arrives.
    // ------------------------------------------------------------------
    logic [DL_W-1:0] dl_in;
    logic [DL_W-1:0] dl_out;
    logic            d_valid;
    logic            d_active;
    logic            d_hs;
    logic            d_vs;

`ifdef VGA_TEST_PATTERN_EN
    logic [BAR_IW-1:0] bar_idx;
    logic [BAR_IW-1:0] d_bar;

    assign bar_idx = BAR_IW'(x_int / BAR_W);
    assign dl_in   = {1'b1, pos_active, hs_act, vs_act, bar_idx};
    assign {d_valid, d_active, d_hs, d_vs, d_bar} = dl_out;
`else
    assign dl_in   = {1'b1, pos_active, hs_act, vs_act};
    assign {d_valid, d_active, d_hs, d_vs} = dl_out;
`endif

    vga_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIX_LAT)
    ) u_delay (
        .clk  (pll_clk),
        .rst  (rst),
        .en   (pix_en),
        .din  (dl_in),
        .dout (dl_out)
    );

    // ------------------------------------------------------------------
    // Colour source selection
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;

    // Pick external colour, or the bar colour for the delayed x when enabled.
    always_comb begin
        src_r = rgb_r_i;
        src_g = rgb_g_i;
        src_b = rgb_b_i;
`ifdef VGA_TEST_PATTERN_EN
        if (test_pat_i) begin
            src_r = {COLOR_W{BAR_RGB[d_bar][2]}};
            src_g = {COLOR_W{BAR_RGB[d_bar][1]}};
            src_b = {COLOR_W{BAR_RGB[d_bar][0]}};
        end
`endif
    end

    // ------------------------------------------------------------------
    // PMOD output registers
    // ------------------------------------------------------------------
    logic pix_on;

    assign pix_on = d_valid && d_active;

    // Register colour and sync together; blank colour outside the visible area.
    always_ff @(posedge pll_clk) begin
        if (rst) begin
            vga_r_o  <= '0;
            vga_g_o  <= '0;
            vga_b_o  <= '0;
            vga_hs_o <= ~H_POL;
            vga_vs_o <= ~V_POL;
        end else if (pix_en) begin
            vga_r_o  <= pix_on ? src_r : '0;
            vga_g_o  <= pix_on ? src_g : '0;
            vga_b_o  <= pix_on ? src_b : '0;
            vga_hs_o <= (d_valid && d_hs) ? H_POL : ~H_POL;
            vga_vs_o <= (d_valid && d_vs) ? V_POL : ~V_POL;
        end
    end

endmodule

// File: tb/tb_vga_pmod_timing.sv
// Bench for vga_pmod_timing: four instances with a small 14x7 raster and
// different pixel latencies / sync polarities share one stimulus stream.
// Expected values come from the raster position computed arithmetically
// from the count of enabled cycles since reset.
module tb_vga_pmod_timing;

    localparam int N  = 4;
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    localparam int LAT [N] = '{2, 0, 1, 5};
    localparam bit POL [N] = '{1'b0, 1'b0, 1'b1, 1'b1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pix_en;
`ifdef VGA_TEST_PATTERN_EN
    logic test_pat;
    bit   last_tp;
    localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                        3'b101, 3'b100, 3'b001, 3'b000};
`endif

    logic [3:0]  x_w   [N];
    logic [2:0]  y_w   [N];
    logic        act_w [N];
    logic        sof_w [N];
    logic [3:0]  r_i   [N];
    logic [3:0]  g_i   [N];
    logic [3:0]  b_i   [N];
    logic [3:0]  r_w   [N];
    logic [3:0]  g_w   [N];
    logic [3:0]  b_w   [N];
    logic        hs_w  [N];
    logic        vs_w  [N];
    logic [15:0] fc_w  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_pmod_timing #(
            .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
            .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
            .H_POL    (POL[g]), .V_POL (POL[g]),
            .COLOR_W  (4), .PIX_LAT (LAT[g])
        ) u_dut (
            .pll_clk     (clk),
            .rst         (rst),
            .pix_en      (pix_en),
            .x_o         (x_w[g]),
            .y_o         (y_w[g]),
            .active_o    (act_w[g]),
            .sof_o       (sof_w[g]),
            .rgb_r_i     (r_i[g]),
            .rgb_g_i     (g_i[g]),
            .rgb_b_i     (b_i[g]),
`ifdef VGA_TEST_PATTERN_EN
            .test_pat_i  (test_pat),
`endif
            .vga_r_o     (r_w[g]),
            .vga_g_o     (g_w[g]),
            .vga_b_o     (b_w[g]),
            .vga_hs_o    (hs_w[g]),
            .vga_vs_o    (vs_w[g]),
            .frame_cnt_o (fc_w[g])
        );
    end

    // ---------------- reference model ----------------
    int e;        // enabled cycles since last reset = pixel index on x_o/y_o
    int checks;
    int passes;
    int fails;

    function automatic int px(input int p);
        return p % HT;
    endfunction

    function automatic int py(input int p);
        return (p / HT) % VT;
    endfunction

    function automatic bit visible(input int p);
        return (px(p) < HA) && (py(p) < VA);
    endfunction

    task automatic check(input string tag, input int g, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h at pixel %0d", tag, g, obs, exp, e);
        end
    endtask

    // ---------------- driver ----------------
    // The pixel source returns colour for the position shown LAT cycles ago:
    // r = x, g = y, b = x ^ y. Before that, and while disabled, drive junk.
    task automatic drive_rgb();
        for (int g = 0; g < N; g++) begin
            int q;
            q = e - LAT[g];
            if (q >= 0 && pix_en && !rst) begin
                r_i[g] = 4'(px(q));
                g_i[g] = 4'(py(q));
                b_i[g] = 4'(px(q) ^ py(q));
            end else begin
                r_i[g] = 4'($urandom_range(0, 15));
                g_i[g] = 4'($urandom_range(0, 15));
                b_i[g] = 4'($urandom_range(0, 15));
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        for (int g = 0; g < N; g++) begin
            int         p;
            logic [3:0] er, eg, eb;
            logic       ehs, evs;
            check("x", g, 32'(x_w[g]), 32'(px(e)));
            check("y", g, 32'(y_w[g]), 32'(py(e)));
            check("active", g, 32'(act_w[g]), 32'(visible(e)));
            check("frame", g, 32'(fc_w[g]), 32'((e / (HT * VT)) % 65536));
            p = e - 1 - LAT[g];
            er = 4'd0; eg = 4'd0; eb = 4'd0;
            ehs = ~POL[g]; evs = ~POL[g];
            if (p >= 0) begin
                if (visible(p)) begin
                    er = 4'(px(p)); eg = 4'(py(p)); eb = 4'(px(p) ^ py(p));
`ifdef VGA_TEST_PATTERN_EN
                    if (last_tp) begin
                        er = BARS[px(p) * 8 / HA][2] ? 4'hF : 4'h0;
                        eg = BARS[px(p) * 8 / HA][1] ? 4'hF : 4'h0;
                        eb = BARS[px(p) * 8 / HA][0] ? 4'hF : 4'h0;
                    end
`endif
                end
                if (px(p) >= HA + HF && px(p) < HA + HF + HS) ehs = POL[g];
                if (py(p) >= VA + VF && py(p) < VA + VF + VS) evs = POL[g];
            end
            check("pin_r", g, 32'(r_w[g]), 32'(er));
            check("pin_g", g, 32'(g_w[g]), 32'(eg));
            check("pin_b", g, 32'(b_w[g]), 32'(eb));
            check("pin_hs", g, 32'(hs_w[g]), 32'(ehs));
            check("pin_vs", g, 32'(vs_w[g]), 32'(evs));
        end
    endtask

    // One clock: apply inputs, check the combinational sof, then the registers.
    task automatic step(input bit en, input bit r);
        pix_en = en;
        rst    = r;
        drive_rgb();
        #1;
        for (int g = 0; g < N; g++) begin
            check("sof", g, 32'(sof_w[g]), 32'(en && !r && (e % (HT * VT) == 0)));
        end
        @(posedge clk);
        if (r) begin
            e = 0;
        end else if (en) begin
            e++;
`ifdef VGA_TEST_PATTERN_EN
            last_tp = test_pat;
`endif
        end
        #1;
        check_outputs();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit found;
        checks = 0; passes = 0; fails = 0; e = 0;
        rst = 1'b1; pix_en = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        test_pat = 1'b0; last_tp = 1'b0;
`endif
        for (int g = 0; g < N; g++) begin
            r_i[g] = 4'd0; g_i[g] = 4'd0; b_i[g] = 4'd0;
        end

        // Reset, including a cycle with pix_en low while in reset.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // Continuous enable: three full frames.
        for (int i = 0; i < 294; i++) step(1'b1, 1'b0);
        for (int g = 0; g < N; g++) check("frame_after_294", g, 32'(fc_w[g]), 32'd3);

        // Half-rate enable.
        for (int i = 0; i < 200; i++) step((i % 2) == 0, 1'b0);

        // Random enable pattern.
        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, 1'b0);

        // Reset mid-frame at x=5, y=2.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (px(e) == 5 && py(e) == 2) found = 1'b1;
            else step(1'b1, 1'b0);
        end
        check("reach_x5y2", 0, 32'(found), 32'd1);
        check("pre_rst_x", 0, 32'(x_w[0]), 32'd5);
        check("pre_rst_y", 0, 32'(y_w[0]), 32'd2);
        step(1'b1, 1'b1);
        for (int i = 0; i < 120; i++) step(1'b1, 1'b0);

        // Random enable with occasional resets.
        for (int i = 0; i < 600; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars, then back to the external source.
        test_pat = 1'b1;
        for (int i = 0; i < 200; i++) step($urandom_range(0, 3) != 0, 1'b0);
        test_pat = 1'b0;
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
